// File: rtl/eof_detect_mr.sv
// End-of-frame detector for ISO 14443-A Modified Miller reader-to-card frames.
// Arms on SoF, then watches carrier/pause run lengths for EoF or a broken pause.
module eof_detect_mr #(
  parameter int BASE_ETU    = 32,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       in_clk,
  input  logic       in_PoR,
  input  logic       in_data,
  input  logic       in_z_detected,
  input  logic       in_enable,
  input  logic [1:0] in_rate,
  output logic       out_eof,
  output logic       out_frame_active,
  output logic       out_pause_err
);

  typedef enum logic {IDLE, ARMED} state_t;

  localparam logic [CNT_W-1:0] BASE    = CNT_W'(BASE_ETU);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic [1:0]       rate_q, rate_next;
  logic [CNT_W-1:0] hi_cnt, lo_cnt, hi_next, lo_next;
  logic [CNT_W-1:0] hi_inc, lo_inc;
  logic [CNT_W-1:0] etu, t_high, t_low;
  logic             eof_next, err_next;
  logic             d_s;

  // Synchroniser flops reset to carrier-present so reset release never looks like a pause.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign d_s = in_data;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge in_clk or negedge in_PoR) begin
        if (!in_PoR) sync_q <= '1;
        else         sync_q <= (sync_q << 1) | SYNC_STAGES'(in_data);
      end
      assign d_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign etu    = BASE >> rate_q;
  assign t_high = etu + (etu >> 1);
  assign t_low  = etu >> 1;

  assign hi_inc = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + 1'b1;
  assign lo_inc = (lo_cnt == CNT_MAX) ? lo_cnt : lo_cnt + 1'b1;

  // Exit decisions use the post-increment count so the pulse lands on the edge the run completes.
  always_comb begin
    state_next = state;
    rate_next  = rate_q;
    hi_next    = '0;
    lo_next    = '0;
    eof_next   = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (in_z_detected && in_enable) begin
          state_next = ARMED;
          rate_next  = in_rate;
        end
      end
      ARMED: begin
        if (!in_enable) begin
          state_next = IDLE;
        end else if (d_s) begin
          if (hi_inc >= t_high) begin
            eof_next   = 1'b1;
            state_next = IDLE;
          end else begin
            hi_next = hi_inc;
          end
        end else begin
          if (lo_inc > t_low) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            lo_next = lo_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_PoR) begin
    if (!in_PoR) begin
      state         <= IDLE;
      rate_q        <= 2'd0;
      hi_cnt        <= '0;
      lo_cnt        <= '0;
      out_eof       <= 1'b0;
      out_pause_err <= 1'b0;
    end else begin
      state         <= state_next;
      rate_q        <= rate_next;
      hi_cnt        <= hi_next;
      lo_cnt        <= lo_next;
      out_eof       <= eof_next;
      out_pause_err <= err_next;
    end
  end

  assign out_frame_active = (state == ARMED);

  a_exclusive_pulses: assert property (@(posedge in_clk) disable iff (!in_PoR)
    !(out_eof && out_pause_err));

endmodule

// File: tb/tb_eof_detect_mr.sv
// Bench for eof_detect_mr: vector table, directed frame scenarios and a random run
// compared cycle by cycle against a run-length model of the frame rules.
module tb_eof_detect_mr;

  localparam int BASE = 32;
  localparam int SYNC = 2;

  logic       in_clk = 1'b0;
  logic       in_PoR;
  logic       in_data;
  logic       in_z_detected;
  logic       in_enable;
  logic [1:0] in_rate;
  logic       out_eof, out_frame_active, out_pause_err;

  int checks   = 0;
  int failures = 0;

  eof_detect_mr #(.BASE_ETU(BASE), .CNT_W(8), .SYNC_STAGES(SYNC)) dut (
    .in_clk(in_clk), .in_PoR(in_PoR), .in_data(in_data),
    .in_z_detected(in_z_detected), .in_enable(in_enable), .in_rate(in_rate),
    .out_eof(out_eof), .out_frame_active(out_frame_active),
    .out_pause_err(out_pause_err)
  );

  always #5 in_clk = ~in_clk;

  // Reference: keeps the sampled envelope since arming and measures the trailing run.
  bit m_armed, m_eof, m_err;
  int m_rate;
  bit hist[$];
  bit m_sync[$];

  task automatic model_reset();
    m_armed = 0; m_eof = 0; m_err = 0; m_rate = 0;
    hist.delete();
    m_sync.delete();
    repeat (SYNC) m_sync.push_back(1'b1);
  endtask

  task automatic model_edge(input bit d, input bit z, input bit en, input int r);
    bit ds;
    int etu, th, tl, run;
    ds = (SYNC == 0) ? d : m_sync[0];
    if (SYNC > 0) begin
      m_sync.push_back(d);
      void'(m_sync.pop_front());
    end
    m_eof = 0;
    m_err = 0;
    if (!m_armed) begin
      if (z && en) begin
        m_armed = 1;
        m_rate  = r;
        hist.delete();
      end
    end else if (!en) begin
      m_armed = 0;
    end else begin
      hist.push_back(ds);
      if (hist.size() > 256) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0 && hist[i] == ds; i--) run++;
      etu = BASE / (1 << m_rate);
      th  = etu * 3 / 2;
      tl  = etu / 2;
      if (ds && run >= th) begin
        m_eof = 1; m_armed = 0;
      end else if (!ds && run > tl) begin
        m_err = 1; m_armed = 0;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, compare 1 ns later.
  task automatic apply_stimulus(input bit d, input bit z, input bit en, input logic [1:0] r);
    in_data = d; in_z_detected = z; in_enable = en; in_rate = r;
    @(posedge in_clk);
    model_edge(d, z, en, int'(r));
    #1;
    check_output("eof_vs_model",    out_eof,          m_eof);
    check_output("active_vs_model", out_frame_active, m_armed);
    check_output("err_vs_model",    out_pause_err,    m_err);
    @(negedge in_clk);
  endtask

  bit wave[$];

  task automatic play(input int extra_high, input logic [1:0] r,
                      output int eof_step, output int err_step, output logic act_at_eof);
    int n;
    eof_step = 0; err_step = 0; act_at_eof = 1'bx;
    n = wave.size();
    for (int s = 1; s <= n + extra_high; s++) begin
      apply_stimulus((s <= n) ? wave[s-1] : 1'b1, 1'b0, 1'b1, r);
      if (out_eof && eof_step == 0) begin
        eof_step = s; act_at_eof = out_frame_active;
      end
      if (out_pause_err && err_step == 0) err_step = s;
    end
  endtask

  typedef struct {
    bit d, z, en;
    logic [1:0] r;
    bit e_eof, e_act, e_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int eof_s, err_s, eof_cnt, run_left;
    logic act_e;
    bit d;
    int bits[6] = '{0, 1, 1, 0, 0, 0};
    int prev;

    in_PoR = 1'b0; in_data = 1'b1; in_z_detected = 1'b0; in_enable = 1'b1; in_rate = 2'd0;
    model_reset();
    repeat (3) @(negedge in_clk);
    check_output("reset_eof",    out_eof,          1'b0);
    check_output("reset_active", out_frame_active, 1'b0);
    check_output("reset_err",    out_pause_err,    1'b0);
    in_PoR = 1'b1;
    @(negedge in_clk);

    // Rate 3 (T_high 6, T_low 2): EoF, pause error, disabled z, enable drop.
    vecs.push_back('{1,1,1,2'd3, 0,1,0});
    for (int i = 0; i < 5; i++) vecs.push_back('{1,0,1,2'd0, 0,1,0});
    vecs.push_back('{1,0,1,2'd0, 1,0,0});
    vecs.push_back('{1,0,1,2'd0, 0,0,0});
    vecs.push_back('{1,1,1,2'd3, 0,1,0});
    vecs.push_back('{0,0,1,2'd3, 0,1,0});
    vecs.push_back('{0,0,1,2'd3, 0,1,0});
    vecs.push_back('{0,0,1,2'd3, 0,1,0});
    vecs.push_back('{0,0,1,2'd3, 0,1,0});
    vecs.push_back('{0,0,1,2'd3, 0,0,1});
    vecs.push_back('{0,1,0,2'd3, 0,0,0});
    vecs.push_back('{1,0,1,2'd3, 0,0,0});
    vecs.push_back('{1,1,1,2'd3, 0,1,0});
    vecs.push_back('{1,0,0,2'd3, 0,0,0});
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].d, vecs[i].z, vecs[i].en, vecs[i].r);
      check_output($sformatf("vec%0d_eof", i),    out_eof,          vecs[i].e_eof);
      check_output($sformatf("vec%0d_active", i), out_frame_active, vecs[i].e_act);
      check_output($sformatf("vec%0d_err", i),    out_pause_err,    vecs[i].e_err);
    end
    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b1, 2'd0);

    // Rate 0, carrier held: EoF on the 48th edge after arming, frame_active falls with it.
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd0);
    wave.delete();
    play(60, 2'd0, eof_s, err_s, act_e);
    check_output("r0_eof_latency", eof_s, 48);
    check_output("r0_active_at_eof", act_e, 1'b0);
    check_output("r0_no_err", err_s, 0);

    // 17-cycle pause aborts (2 extra steps of synchroniser delay); 16-cycle pause does not.
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd0);
    wave.delete();
    repeat (17) wave.push_back(1'b0);
    play(20, 2'd0, eof_s, err_s, act_e);
    check_output("pause17_err_step", err_s, 19);
    check_output("pause17_no_eof", eof_s, 0);
    check_output("pause17_idle", out_frame_active, 1'b0);

    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd0);
    wave.delete();
    repeat (16) wave.push_back(1'b0);
    play(60, 2'd0, eof_s, err_s, act_e);
    check_output("pause16_no_err", err_s, 0);
    check_output("pause16_eof_step", eof_s, 16 + SYNC + 48);

    // Rate latched at arming: later rate change does not move the 6-edge threshold.
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd3);
    wave.delete();
    play(10, 2'd0, eof_s, err_s, act_e);
    check_output("r3_eof_latency", eof_s, 6);

    // Modified Miller frame at 106k: Z(0) X(1) X(1) Y(0) Z(0) Z(0) then Y; last pause ends at cycle 168.
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd0);
    wave.delete();
    prev = 0;
    foreach (bits[b]) begin
      for (int c = 0; c < BASE; c++) begin
        if (bits[b] == 1) wave.push_back(!(c >= 16 && c < 24));
        else if (prev == 0) wave.push_back(!(c < 8));
        else wave.push_back(1'b1);
      end
      prev = bits[b];
    end
    play(80, 2'd0, eof_s, err_s, act_e);
    check_output("miller_eof_step", eof_s, 168 + 48 + SYNC);
    check_output("miller_no_err", err_s, 0);

    // Reset mid-frame at hi_cnt = 30, then long carrier without z.
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd0);
    repeat (30) apply_stimulus(1'b1, 1'b0, 1'b1, 2'd0);
    check_output("prereset_active", out_frame_active, 1'b1);
    #2 in_PoR = 1'b0;
    #1;
    check_output("midreset_eof",    out_eof,          1'b0);
    check_output("midreset_active", out_frame_active, 1'b0);
    check_output("midreset_err",    out_pause_err,    1'b0);
    model_reset();
    @(negedge in_clk);
    @(negedge in_clk);
    in_PoR = 1'b1;
    eof_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b1, 2'd0);
      if (out_eof || out_frame_active) eof_cnt++;
    end
    check_output("postreset_quiet", eof_cnt, 0);

    // Random envelope, z, enable and rate against the model.
    run_left = 0;
    d = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        d = ~d;
        run_left = d ? $urandom_range(1, 60) : $urandom_range(1, 24);
      end
      run_left--;
      apply_stimulus(d, ($urandom_range(0, 11) == 0), ($urandom_range(0, 39) != 0),
                     2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eof_detect_mr.md
EOF_DETECT_MR -- requirements
Module: eof_detect_mr

Interface
REQ-001 SHALL have parameter BASE_ETU, default 32, in_clk cycles per ETU at 106 kbps (3.39 MHz clock).
REQ-002 SHALL have parameter CNT_W, default 8, run-counter width; BASE_ETU*3/2 SHALL fit in CNT_W bits.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal 0..3, number of in_data synchroniser flops.
REQ-004 in_clk  input  1  sole clock, all logic on rising edge.
REQ-005 in_PoR  input  1  asynchronous active-low reset.
REQ-006 in_data  input  1  demodulated envelope, 1 = carrier, 0 = pause.
REQ-007 in_z_detected  input  1  one-cycle SoF pulse from SoF detector.
REQ-008 in_enable  input  1  block enable, level.
REQ-009 in_rate  input  2  bit rate: 0=106, 1=212, 2=424, 3=848 kbps.
REQ-010 out_eof  output  1  one-cycle pulse, end of frame detected.
REQ-011 out_frame_active  output  1  high while a frame is armed.
REQ-012 out_pause_err  output  1  one-cycle pulse, over-long pause aborted frame.

Function
REQ-013 d_s = in_data delayed by SYNC_STAGES flops; all run counting SHALL use d_s only.
REQ-014 ETU_r = BASE_ETU >> rate; T_high = ETU_r + (ETU_r >> 1); T_low = ETU_r >> 1 (defaults: rate 0 -> 48/16, rate 3 -> 6/2).
REQ-015 rate SHALL be latched from in_rate on the arming cycle; in_rate changes while armed SHALL be ignored.
REQ-016 FSM states: IDLE, ARMED; out_frame_active = (state == ARMED), registered.
REQ-017 IDLE -> ARMED on in_z_detected=1 with in_enable=1; both run counters cleared that cycle.
REQ-018 in IDLE, in_z_detected with in_enable=0 SHALL be ignored.
REQ-019 ARMED: hi_cnt increments per cycle with d_s=1 and clears on d_s=0; lo_cnt increments per cycle with d_s=0 and clears on d_s=1; both saturate at all-ones.
REQ-020 ARMED and hi_cnt reaching T_high SHALL produce out_eof=1 for exactly one cycle and go to IDLE, with out_frame_active falling on that same cycle.
REQ-021 ARMED and lo_cnt reaching T_low+1 SHALL produce out_pause_err=1 for one cycle and go to IDLE; out_eof SHALL stay 0.
REQ-022 in_z_detected while ARMED SHALL be ignored (no counter restart).
REQ-023 in_z_detected arriving in the same cycle as an EoF or error exit SHALL be ignored; re-arming requires a later pulse.
REQ-024 in_enable=0 while ARMED SHALL force IDLE on the next edge with no out_eof and no out_pause_err.
REQ-025 out_eof and out_pause_err SHALL never be high in the same cycle.
REQ-026 EoF latency: with d_s high continuously from arming, out_eof SHALL rise on the T_high-th edge after the arming edge.
REQ-027 Valid Modified Miller runs (high at most 1.5 ETU minus pause, low at most T_low) SHALL NOT trigger either output.

Reset
REQ-028 in_PoR=0 SHALL asynchronously force IDLE, hi_cnt=lo_cnt=0, latched rate=0, synchroniser flops=1, out_eof=0, out_frame_active=0, out_pause_err=0.
REQ-029 Reset release SHALL leave the block in IDLE; a reset pulse mid-frame SHALL discard the frame with no output pulse.

Verification
REQ-030 rate=0, enable=1, z pulse, in_data held 1 -> out_eof one-cycle pulse 48 edges after arming (50 edges after the last in_data rise with SYNC_STAGES=2); frame_active falls with it.
REQ-031 rate=0, armed, Miller sequence 0,1,1,0,1 (8-clock pauses), then logic 0 + Y -> no pulse during data; out_eof once, 48 cycles after the final pause ends.
REQ-032 rate=0, armed, in_data low for 17 cycles -> out_pause_err pulse, out_eof stays 0, state IDLE; 16-cycle low -> no error.
REQ-033 rate=3, z pulse, in_data high -> out_eof after 6 edges; in_rate switched to 0 mid-frame -> threshold stays 6.
REQ-034 armed, in_PoR low at hi_cnt=30 -> all outputs 0 immediately; after release in_data high for 100 cycles without z -> no out_eof.
REQ-035 enable=0 with z pulse -> frame_active stays 0; enable dropped while armed -> IDLE next edge, no pulses.
